// File: rtl/anti_theft_pkg.sv
// Shared types for the anti-theft controller.
// State codes and timer interval-select codes.
package anti_theft_pkg;

    typedef enum logic [2:0] {
        ARMED_IDLE        = 3'd0,
        TRIG_COUNTDOWN    = 3'd1,
        SOUND_ALARM       = 3'd2,
        DISARMED          = 3'd3,
        WAIT_DRIVER_OPEN  = 3'd4,
        WAIT_DRIVER_CLOSE = 3'd5,
        ARM_DELAY         = 3'd6,
        LOCKOUT           = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        IV_ARM    = 2'd0,
        IV_DRIVER = 2'd1,
        IV_PASS   = 2'd2,
        IV_ALARM  = 2'd3
    } ival_e;

endpackage

// File: rtl/at_tick_timer.sv
// Tick prescaler plus loadable tick down-counter.
// expired is high on the tick that finishes the interval.
module at_tick_timer #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tick_o,
    output logic             expired_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]    pre_q;
    logic [CNT_W-1:0] cnt_q;

    assign tick_o    = (pre_q == PMAX);
    assign expired_o = tick_o && (cnt_q == CNT_W'(1));

    // Prescaler free-runs; a load realigns it and sets the interval.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            pre_q <= '0;
            cnt_q <= load_val_i;
        end else begin
            pre_q <= tick_o ? '0 : pre_q + 1'b1;
            if (tick_o && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/anti_theft_fsm_multi.sv
// Vehicle anti-theft controller: arming, entry delay,
// alarm with re-trigger counting and lockout.
module anti_theft_fsm_multi
    import anti_theft_pkg::*;
#(
    parameter int N_DOORS     = 4,
    parameter int TICK_DIV    = 25_000_000,
    parameter int T_ARM       = 6,
    parameter int T_DRIVER    = 8,
    parameter int T_PASS      = 15,
    parameter int T_ALARM     = 20,
    parameter int MAX_RETRIG  = 3,
    parameter int SIREN_PULSE = 0,
    parameter int CNT_W       = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                ignition,
    input  logic [N_DOORS-1:0]                  door,
    output logic                                led,
    output logic                                siren,
    output logic [2:0]                          state_o,
    output logic [N_DOORS-1:0]                  trigger_src,
    output logic [$clog2(MAX_RETRIG+1)-1:0]     alarm_count,
    output logic                                lockout
);

    localparam int AW = $clog2(MAX_RETRIG + 1);
    localparam logic [AW-1:0] MAXC = AW'(MAX_RETRIG);

    state_e             state_q, state_d;
    logic [N_DOORS-1:0] src_q, src_d;
    logic [AW-1:0]      acnt_q, acnt_d, acnt_inc;
    logic               blink_q, siren_q;
    logic               load;
    ival_e              sel;
    logic [CNT_W-1:0]   load_val;
    logic               tick, expired;

    at_tick_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (load),
        .load_val_i (load_val),
        .tick_o     (tick),
        .expired_o  (expired)
    );

    assign acnt_inc = (acnt_q == MAXC) ? acnt_q : acnt_q + 1'b1;

    // Interval lookup for the timer load.
    always_comb begin
        load_val = CNT_W'(T_ARM);
        unique case (sel)
            IV_ARM:    load_val = CNT_W'(T_ARM);
            IV_DRIVER: load_val = CNT_W'(T_DRIVER);
            IV_PASS:   load_val = CNT_W'(T_PASS);
            IV_ALARM:  load_val = CNT_W'(T_ALARM);
            default:   load_val = CNT_W'(T_ARM);
        endcase
    end

    // Next-state decode: ignition first, then expiry, then doors.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        acnt_d  = acnt_q;
        load    = 1'b0;
        sel     = IV_ARM;
        unique case (state_q)
            ARMED_IDLE: begin
                if (ignition) begin
                    state_d = DISARMED;
                end else if (|door) begin
                    state_d = TRIG_COUNTDOWN;
                    load    = 1'b1;
                    sel     = door[0] ? IV_DRIVER : IV_PASS;
                    src_d   = door;
                end
            end
            TRIG_COUNTDOWN: begin
                if (ignition) begin
                    state_d = DISARMED;
                end else if (expired) begin
                    state_d = SOUND_ALARM;
                    load    = 1'b1;
                    sel     = IV_ALARM;
                end
            end
            SOUND_ALARM: begin
                if (ignition) begin
                    state_d = DISARMED;
                end else if (expired) begin
                    acnt_d  = acnt_inc;
                    state_d = (acnt_inc == MAXC) ? LOCKOUT : ARMED_IDLE;
                end
            end
            LOCKOUT: begin
                if (ignition)
                    state_d = DISARMED;
            end
            DISARMED: begin
                if (!ignition) begin
                    if (door == '0) begin
                        state_d = ARM_DELAY;
                        load    = 1'b1;
                        sel     = IV_ARM;
                    end else begin
                        state_d = WAIT_DRIVER_OPEN;
                    end
                end
            end
            WAIT_DRIVER_OPEN: begin
                if (ignition)
                    state_d = DISARMED;
                else if (door[0])
                    state_d = WAIT_DRIVER_CLOSE;
            end
            WAIT_DRIVER_CLOSE: begin
                if (ignition) begin
                    state_d = DISARMED;
                end else if (door == '0) begin
                    state_d = ARM_DELAY;
                    load    = 1'b1;
                    sel     = IV_ARM;
                end
            end
            ARM_DELAY: begin
                if (ignition)
                    state_d = DISARMED;
                else if (expired)
                    state_d = ARMED_IDLE;
                else if (|door)
                    state_d = WAIT_DRIVER_CLOSE;
            end
            default: state_d = ARMED_IDLE;
        endcase
        if (state_d == DISARMED) begin
            acnt_d = '0;
            src_d  = '0;
        end
    end

    // State, report registers and the blink/siren flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARMED_IDLE;
            src_q   <= '0;
            acnt_q  <= '0;
            blink_q <= 1'b0;
            siren_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            acnt_q  <= acnt_d;
            if (state_d != state_q) begin
                blink_q <= 1'b0;
                siren_q <= 1'b1;
            end else if (tick) begin
                blink_q <= ~blink_q;
                if (SIREN_PULSE != 0)
                    siren_q <= ~siren_q;
            end
        end
    end

    // LED/siren decode from state and the pattern flops.
    always_comb begin
        led = 1'b0;
        unique case (state_q)
            ARMED_IDLE:     led = blink_q;
            TRIG_COUNTDOWN,
            SOUND_ALARM,
            LOCKOUT,
            ARM_DELAY:      led = 1'b1;
            default:        led = 1'b0;
        endcase
    end

    assign siren       = (state_q == SOUND_ALARM) && siren_q;
    assign lockout     = (state_q == LOCKOUT);
    assign state_o     = state_q;
    assign trigger_src = src_q;
    assign alarm_count = acnt_q;

endmodule

// File: tb/tb_anti_theft_fsm_multi.sv
// Directed table-driven bench for anti_theft_fsm_multi.
// Second instance uses the pulsed siren.
module tb_anti_theft_fsm_multi;

    logic       clk;
    logic       reset_n;
    logic       ignition;
    logic [3:0] door;

    logic       led0, siren0, lock0;
    logic [2:0] st0;
    logic [3:0] src0;
    logic [1:0] cnt0;

    logic       led1, siren1, lock1;
    logic [2:0] st1;
    logic [3:0] src1;
    logic [1:0] cnt1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       ign;
        logic [3:0] door;
        int         n;
        logic [2:0] st;
        logic       led;
        logic       sir;
        logic       lck;
        logic [3:0] src;
        logic [1:0] cnt;
    } vec_t;

    vec_t vq[$];

    anti_theft_fsm_multi #(
        .N_DOORS(4), .TICK_DIV(4), .T_ARM(2), .T_DRIVER(2),
        .T_PASS(3), .T_ALARM(2), .MAX_RETRIG(2),
        .SIREN_PULSE(0), .CNT_W(8)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .ignition(ignition),
        .door(door), .led(led0), .siren(siren0), .state_o(st0),
        .trigger_src(src0), .alarm_count(cnt0), .lockout(lock0)
    );

    anti_theft_fsm_multi #(
        .N_DOORS(4), .TICK_DIV(4), .T_ARM(2), .T_DRIVER(2),
        .T_PASS(3), .T_ALARM(2), .MAX_RETRIG(2),
        .SIREN_PULSE(1), .CNT_W(8)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .ignition(ignition),
        .door(door), .led(led1), .siren(siren1), .state_o(st1),
        .trigger_src(src1), .alarm_count(cnt1), .lockout(lock1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ig, input logic [3:0] d, input int n,
                       input logic [2:0] s, input logic l, input logic sr,
                       input logic lk, input logic [3:0] sc,
                       input logic [1:0] c);
        vec_t v;
        v.ign = ig; v.door = d; v.n = n; v.st = s; v.led = l;
        v.sir = sr; v.lck = lk; v.src = sc; v.cnt = c;
        vq.push_back(v);
    endtask

    initial begin
        // passenger door pulse: 12-cycle entry delay, 8-cycle alarm
        add(0, 4'b0100,  1, 1, 1, 0, 0, 4'b0100, 0);
        add(0, 4'b0000, 11, 1, 1, 0, 0, 4'b0100, 0);
        add(0, 4'b0000,  1, 2, 1, 1, 0, 4'b0100, 0);
        add(0, 4'b0000,  7, 2, 1, 1, 0, 4'b0100, 0);
        add(0, 4'b0000,  1, 0, 0, 0, 0, 4'b0100, 1);
        // driver door, ignition mid-countdown
        add(0, 4'b0101,  1, 1, 1, 0, 0, 4'b0101, 1);
        add(0, 4'b0000,  4, 1, 1, 0, 0, 4'b0101, 1);
        add(1, 4'b0000,  1, 3, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0000,  2, 3, 0, 0, 0, 4'b0000, 0);
        // arm: 8 cycles of ARM_DELAY
        add(0, 4'b0000,  1, 6, 1, 0, 0, 4'b0000, 0);
        add(0, 4'b0000,  7, 6, 1, 0, 0, 4'b0000, 0);
        add(0, 4'b0000,  1, 0, 0, 0, 0, 4'b0000, 0);
        // driver delay runs the full 8 cycles
        add(0, 4'b0001,  1, 1, 1, 0, 0, 4'b0001, 0);
        add(0, 4'b0000,  7, 1, 1, 0, 0, 4'b0001, 0);
        add(0, 4'b0000,  1, 2, 1, 1, 0, 4'b0001, 0);
        add(0, 4'b0000,  3, 2, 1, 1, 0, 4'b0001, 0);
        add(1, 4'b0000,  1, 3, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b0000,  1, 6, 1, 0, 0, 4'b0000, 0);
        add(0, 4'b0000,  7, 6, 1, 0, 0, 4'b0000, 0);
        add(0, 4'b0000,  1, 0, 0, 0, 0, 4'b0000, 0);
        // door[1] held: two episodes then LOCKOUT
        add(0, 4'b0010,  1, 1, 1, 0, 0, 4'b0010, 0);
        add(0, 4'b0010, 11, 1, 1, 0, 0, 4'b0010, 0);
        add(0, 4'b0010,  1, 2, 1, 1, 0, 4'b0010, 0);
        add(0, 4'b0010,  7, 2, 1, 1, 0, 4'b0010, 0);
        add(0, 4'b0010,  1, 0, 0, 0, 0, 4'b0010, 1);
        add(0, 4'b0010,  1, 1, 1, 0, 0, 4'b0010, 1);
        add(0, 4'b0010, 11, 1, 1, 0, 0, 4'b0010, 1);
        add(0, 4'b0010,  1, 2, 1, 1, 0, 4'b0010, 1);
        add(0, 4'b0010,  7, 2, 1, 1, 0, 4'b0010, 1);
        add(0, 4'b0010,  1, 7, 1, 0, 1, 4'b0010, 2);
        add(0, 4'b1111,  3, 7, 1, 0, 1, 4'b0010, 2);
        add(0, 4'b0000,  3, 7, 1, 0, 1, 4'b0010, 2);
        add(1, 4'b0000,  1, 3, 0, 0, 0, 4'b0000, 0);
        // driver-door arming sequence and ARM_DELAY abort
        add(0, 4'b0001,  1, 4, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b0001,  1, 5, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b0001,  2, 5, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b0000,  1, 6, 1, 0, 0, 4'b0000, 0);
        add(0, 4'b0000,  4, 6, 1, 0, 0, 4'b0000, 0);
        add(0, 4'b0100,  1, 5, 0, 0, 0, 4'b0000, 0);
        add(0, 4'b0000,  1, 6, 1, 0, 0, 4'b0000, 0);
        add(0, 4'b0000,  7, 6, 1, 0, 0, 4'b0000, 0);
        add(0, 4'b0000,  1, 0, 0, 0, 0, 4'b0000, 0);

        reset_n  = 1'b0;
        ignition = 1'b0;
        door     = 4'b0000;
        #3;
        chk("rst_state", 0, st0, 0);
        chk("rst_led", 0, led0, 0);
        chk("rst_siren", 0, siren0, 0);
        #9;
        reset_n = 1'b1;
        #1;
        chk("rel_state", 0, st0, 0);
        chk("rel_src", 0, src0, 0);
        chk("rel_cnt", 0, cnt0, 0);
        chk("rel_lock", 0, lock0, 0);

        // idle blink: toggles every 4 cycles
        step(3); chk("blink", 0, led0, 0);
        step(1); chk("blink", 1, led0, 1);
        step(3); chk("blink", 2, led0, 1);
        step(1); chk("blink", 3, led0, 0);
        step(4); chk("blink", 4, led1, 1);
        chk("idle_siren", 0, siren0, 0);
        step(4); chk("blink", 5, led0, 0);
        chk("idle_state", 0, st0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            ignition = vq[i].ign;
            door     = vq[i].door;
            step(vq[i].n);
            chk("state", i, st0, vq[i].st);
            chk("led", i, led0, vq[i].led);
            chk("siren", i, siren0, vq[i].sir);
            chk("lockout", i, lock0, vq[i].lck);
            chk("src", i, src0, vq[i].src);
            chk("count", i, cnt0, vq[i].cnt);
        end

        // pulsed siren: 1 for one tick, 0 for the next
        door = 4'b0001;
        step(1);
        door = 4'b0000;
        step(7);
        chk("pre_alarm", 0, st1, 1);
        step(1);
        for (int k = 0; k < 6; k++) begin
            chk("pulse_state", k, st1, 2);
            chk("pulse_siren", k, siren1, (k < 4) ? 1 : 0);
            chk("steady_siren", k, siren0, 1);
            if (k < 5) step(1);
        end

        // asynchronous reset mid-alarm
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_state", 0, st0, 0);
        chk("async_led", 0, led0, 0);
        chk("async_siren", 0, siren0, 0);
        chk("async_siren", 1, siren1, 0);
        chk("async_src", 0, src0, 0);
        chk("async_cnt", 0, cnt0, 0);
        chk("async_lock", 0, lock0, 0);
        #4;
        reset_n = 1'b1;
        step(2);
        chk("post_state", 0, st0, 0);
        chk("post_led", 0, led0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/anti_theft_fsm_multi.md
Name: anti_theft_fsm_multi

Overview:
- Next-generation vehicle anti-theft controller: N door/hatch inputs, on-chip tick prescaler and countdown timer (no external Timer/Time_Parameters blocks), per-source entry delay, and optional pulsed siren.
- Adds a re-trigger counter with a LOCKOUT state and a latched trigger-source report for the dashboard/telematics logic.
- Sits between debounced door/ignition inputs and the LED/siren drivers.

Parameters:
- N_DOORS, 4, number of door inputs; bit 0 is the driver door, must be >= 2.
- TICK_DIV, 25_000_000, clk cycles per timer tick (0.5 s at 50 MHz); must be >= 2.
- T_ARM, 6, arm-delay length in ticks; must be >= 1.
- T_DRIVER, 8, entry delay in ticks when the driver door triggers; must be >= 1.
- T_PASS, 15, entry delay in ticks when only non-driver doors trigger; must be >= 1.
- T_ALARM, 20, siren-on duration in ticks; must be >= 1.
- MAX_RETRIG, 3, alarm episodes before LOCKOUT; must be >= 1.
- SIREN_PULSE, 0, 1 = siren toggles every tick, 0 = steady siren.
- CNT_W, 8, tick-counter width; all T_* values must be < 2**CNT_W.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ignition  in  1  key on; synchronous, already debounced
- door  in  N_DOORS  1 = door open; bit 0 is the driver door
- led  out  1  status LED
- siren  out  1  siren drive
- state_o  out  3  current state encoding (debug)
- trigger_src  out  N_DOORS  door vector latched at the last trigger
- alarm_count  out  $clog2(MAX_RETRIG+1)  alarm episodes since last disarm
- lockout  out  1  high while in LOCKOUT

Behaviour:
- Reset, asynchronous on reset_n low:
  - state = ARMED_IDLE.
  - led, siren, lockout, trigger_src, alarm_count, prescaler and tick counter all 0.
- Timer:
  - Entering TRIG_COUNTDOWN, SOUND_ALARM or ARM_DELAY loads cnt with the interval and clears the prescaler.
  - tick pulses for one cycle every TICK_DIV cycles; cnt decrements on each tick.
  - expired = tick && cnt == 1, combinational. The transition registers on the same edge, so residence = T*TICK_DIV cycles exactly.
  - In any other state the prescaler free-runs; it is used for blink.
- Priority in every state: ignition > expiry > door events.
- ARMED_IDLE:
  - led toggles on each tick; led = 0 on entry.
  - ignition -> DISARMED.
  - |door -> TRIG_COUNTDOWN, latching trigger_src = door. Interval is T_DRIVER if door[0] is set, else T_PASS.
- TRIG_COUNTDOWN:
  - led = 1.
  - ignition -> DISARMED.
  - expired -> SOUND_ALARM with interval T_ALARM.
  - Further door activity is ignored.
- SOUND_ALARM:
  - led = 1.
  - siren = 1, or when SIREN_PULSE = 1 siren starts at 1 and toggles on each tick.
  - ignition -> DISARMED.
  - expired: alarm_count++ (saturating). If the new count == MAX_RETRIG -> LOCKOUT, else -> ARMED_IDLE.
  - A door still open in ARMED_IDLE retriggers on the next cycle.
- LOCKOUT:
  - led = 1, siren = 0, lockout = 1.
  - Only ignition exits, to DISARMED.
- DISARMED:
  - led = 0.
  - On entry: alarm_count = 0 and trigger_src = 0.
  - !ignition && door == 0 -> ARM_DELAY with T_ARM.
  - !ignition && |door -> WAIT_DRIVER_OPEN.
- WAIT_DRIVER_OPEN: ignition -> DISARMED; door[0] -> WAIT_DRIVER_CLOSE.
- WAIT_DRIVER_CLOSE: ignition -> DISARMED; door == 0 -> ARM_DELAY with T_ARM.
- ARM_DELAY:
  - led = 1.
  - ignition -> DISARMED.
  - |door -> WAIT_DRIVER_CLOSE, timer abandoned.
  - expired -> ARMED_IDLE.
- Outputs are combinational from state and the blink/siren flops; there are no glitch-free requirements.

Decomposition:
- anti_theft_pkg holds:
  - the state enum (8 codes, 3 bits): ARMED_IDLE=0, TRIG_COUNTDOWN=1, SOUND_ALARM=2, DISARMED=3, WAIT_DRIVER_OPEN=4, WAIT_DRIVER_CLOSE=5, ARM_DELAY=6, LOCKOUT=7;
  - the interval-select codes.
- One sub-module, at_tick_timer: prescaler, loadable down-counter, tick and expired outputs.

Test Plan (TICK_DIV=4, T_ARM=2, T_DRIVER=2, T_PASS=3, T_ALARM=2, MAX_RETRIG=2, N_DOORS=4):
- Reset then idle 16 cycles -> led toggles every 4 cycles; siren 0; state_o 0.
- door=4'b0100 for 1 cycle -> trigger_src=0100; TRIG_COUNTDOWN for 12 cycles; SOUND_ALARM for 8 cycles; then ARMED_IDLE with alarm_count=1.
- door=4'b0101 -> delay is 8 cycles (T_DRIVER). Ignition raised mid-countdown -> DISARMED next edge; siren never asserts; trigger_src and alarm_count cleared.
- Hold door[1]=1 continuously -> two alarm episodes, then LOCKOUT with lockout=1, siren=0. Doors toggled in LOCKOUT -> no change. ignition -> DISARMED.
- From DISARMED: ignition off with door[0]=1, door[0]=0, wait -> ARMED_IDLE after 8 cycles of ARM_DELAY. Door opened at cycle 5 of ARM_DELAY -> WAIT_DRIVER_CLOSE.
- SIREN_PULSE=1: siren pattern 1,0 over 4-cycle ticks during SOUND_ALARM. Assert reset_n=0 mid-alarm -> all outputs 0 immediately, without waiting for a clock edge.
